// File: rtl/nco_clock_gen_if.sv
// Bus bundle for nco_clock_gen: run request, tuning-word handshake and clock/status outputs.
// Burst ports exist only when NCO_CLOCK_GEN_BURST_EN is defined.
interface nco_clock_gen_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 20
);
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_word;
    logic             clk_out;
    logic             busy;
    logic [CNT_W-1:0] edge_count;
`ifdef NCO_CLOCK_GEN_BURST_EN
    logic [15:0]      burst_len;
    logic             burst_done;

    modport master (
        output en, cfg_valid, cfg_word, burst_len,
        input  cfg_ready, clk_out, busy, edge_count, burst_done
    );
    modport slave (
        input  en, cfg_valid, cfg_word, burst_len,
        output cfg_ready, clk_out, busy, edge_count, burst_done
    );
`else
    modport master (
        output en, cfg_valid, cfg_word,
        input  cfg_ready, clk_out, busy, edge_count
    );
    modport slave (
        input  en, cfg_valid, cfg_word,
        output cfg_ready, clk_out, busy, edge_count
    );
`endif
endinterface

// File: rtl/nco_clock_gen.sv
// Phase-accumulator clock generator with glitch-free tuning-word updates on clk_sys.
// Optional burst mode (fixed edge count per run) is enabled by NCO_CLOCK_GEN_BURST_EN.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | acc held at 0, clk_out low, tuning word writes go straight to inc
//  ST_RUN   | accumulating every cycle
//  ST_DRAIN | en dropped (or burst done): finish the current period, then idle
module nco_clock_gen #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 20
) (
    input  logic            clk_sys,
    input  logic            rst,
    nco_clock_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] HALF_WORD = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0] inc, inc_nxt;
    logic [ACC_W-1:0] pend_word, pend_word_nxt;
    logic             pend_flag, pend_flag_nxt;
    logic [CNT_W-1:0] edge_count;

    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             run_rise;
    logic             hs;
    logic [ACC_W-1:0] word_clamped;

    logic             start_ok;
    logic             drain_lock;
    logic             burst_hit;

    assign {carry, sum}  = {1'b0, acc} + {1'b0, inc};
    assign run_rise      = sum[ACC_W-1] & ~acc[ACC_W-1];
    assign hs            = bus.cfg_valid & ~pend_flag;
    assign word_clamped  = bus.cfg_word[ACC_W-1] ? HALF_WORD : bus.cfg_word;

`ifdef NCO_CLOCK_GEN_BURST_EN
    logic [15:0] burst_rem, burst_rem_nxt;
    logic        burst_on, burst_on_nxt;
    logic        burst_drain, burst_drain_nxt;
    logic        burst_hold, burst_hold_nxt;
    logic        burst_done_q, burst_done_nxt;

    // Down-counter of edges left in the burst; terminal count is the last edge.
    assign burst_hit  = (state != ST_IDLE) && burst_on && !burst_drain && run_rise
                        && (burst_rem == 16'd1);
    assign start_ok   = ~burst_hold;
    assign drain_lock = burst_drain;
`else
    assign burst_hit  = 1'b0;
    assign start_ok   = 1'b1;
    assign drain_lock = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            inc        <= '0;
            pend_word  <= '0;
            pend_flag  <= 1'b0;
            edge_count <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            inc       <= inc_nxt;
            pend_word <= pend_word_nxt;
            pend_flag <= pend_flag_nxt;
            if (acc_nxt[ACC_W-1] & ~acc[ACC_W-1])
                edge_count <= edge_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        inc_nxt       = inc;
        pend_word_nxt = pend_word;
        pend_flag_nxt = pend_flag;

        case (state)
            ST_IDLE: begin
                acc_nxt = '0;
                if (hs)
                    inc_nxt = word_clamped;
                if (bus.en && start_ok)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                acc_nxt = sum;
                if (burst_hit || !bus.en)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.en && !drain_lock && !burst_hit) begin
                    state_nxt = ST_RUN;
                    acc_nxt   = sum;
                end else if (carry) begin
                    state_nxt = ST_IDLE;
                    acc_nxt   = '0;
                end else begin
                    acc_nxt = sum;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                acc_nxt   = '0;
            end
        endcase

        // Word changes only land on a carry so every period is whole.
        if (state != ST_IDLE) begin
            if (carry && pend_flag) begin
                inc_nxt       = pend_word;
                pend_flag_nxt = 1'b0;
            end
            if (hs) begin
                if (state_nxt == ST_IDLE) begin
                    inc_nxt       = word_clamped;
                    pend_flag_nxt = 1'b0;
                end else begin
                    pend_word_nxt = word_clamped;
                    pend_flag_nxt = 1'b1;
                end
            end
        end
    end

`ifdef NCO_CLOCK_GEN_BURST_EN
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            burst_rem    <= '0;
            burst_on     <= 1'b0;
            burst_drain  <= 1'b0;
            burst_hold   <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            burst_rem    <= burst_rem_nxt;
            burst_on     <= burst_on_nxt;
            burst_drain  <= burst_drain_nxt;
            burst_hold   <= burst_hold_nxt;
            burst_done_q <= burst_done_nxt;
        end
    end

    always_comb begin
        burst_rem_nxt   = burst_rem;
        burst_on_nxt    = burst_on;
        burst_drain_nxt = burst_drain;
        burst_hold_nxt  = burst_hold;
        burst_done_nxt  = 1'b0;

        if (!bus.en)
            burst_hold_nxt = 1'b0;

        if (state == ST_IDLE && state_nxt == ST_RUN) begin
            burst_rem_nxt   = bus.burst_len;
            burst_on_nxt    = (bus.burst_len != 16'd0);
            burst_drain_nxt = 1'b0;
        end else if (state != ST_IDLE && burst_on && !burst_drain && run_rise) begin
            burst_rem_nxt = burst_rem - 16'd1;
            if (burst_hit) begin
                burst_drain_nxt = 1'b1;
                burst_hold_nxt  = 1'b1;
            end
        end

        if (state != ST_IDLE && state_nxt == ST_IDLE) begin
            burst_drain_nxt = 1'b0;
            burst_done_nxt  = burst_drain;
        end
    end

    assign bus.burst_done = burst_done_q;
`endif

    assign bus.cfg_ready  = ~pend_flag;
    assign bus.clk_out    = acc[ACC_W-1];
    assign bus.busy       = (state != ST_IDLE);
    assign bus.edge_count = edge_count;

endmodule

// File: tb/tb_nco_clock_gen.sv
// Directed bench for nco_clock_gen: frequency, retune, drain, clamp, async reset, burst.
module tb_nco_clock_gen;

    logic clk_sys = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   high_cnt;
    int   first_high;
    int   pulses;

    nco_clock_gen_if #(.ACC_W(32), .CNT_W(20)) bus ();

    nco_clock_gen #(.ACC_W(32), .CNT_W(20)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    initial forever #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_word  = '0;
`ifdef NCO_CLOCK_GEN_BURST_EN
        bus.burst_len = 16'd0;
`endif
        #2;
        chk("rst_clk_out", bus.clk_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.cfg_ready, 1);
        chk("rst_edges", bus.edge_count, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 2^30 word: period 4, 50% duty
        bus.cfg_valid = 1'b1;
        bus.cfg_word  = 32'h4000_0000;
        tick();
        bus.cfg_valid = 1'b0;
        chk("idle_inc_load", dut.inc, 32'h4000_0000);
        bus.en = 1'b1;
        tick();
        chk("run_busy", bus.busy, 1);
        chk("run_start_low", bus.clk_out, 0);
        high_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.clk_out) high_cnt++;
            if (i == 0) chk("first_add_low", bus.clk_out, 0);
            if (i == 1) begin
                chk("first_rise", bus.clk_out, 1);
                chk("first_edge_cnt", bus.edge_count, 1);
            end
        end
        chk("edges_400", bus.edge_count, 100);
        chk("duty_400", high_cnt, 200);

        // retune to 2^29 mid-period
        tick();
        bus.cfg_valid = 1'b1;
        bus.cfg_word  = 32'h2000_0000;
        tick();
        bus.cfg_valid = 1'b0;
        chk("retune_ready_low", bus.cfg_ready, 0);
        chk("retune_rise", bus.clk_out, 1);
        tick();
        chk("retune_ready_mid", bus.cfg_ready, 0);
        chk("retune_old_high", bus.clk_out, 1);
        tick();
        chk("retune_ready_back", bus.cfg_ready, 1);
        chk("retune_inc", dut.inc, 32'h2000_0000);
        chk("retune_carry_low", bus.clk_out, 0);
        high_cnt   = 0;
        first_high = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.clk_out) begin
                high_cnt++;
                if (first_high < 0) first_high = i;
            end
        end
        chk("retune_low_phase", first_high, 3);
        chk("retune_high_cnt", high_cnt, 8);
        chk("retune_edges", bus.edge_count, 103);

        // drop en one cycle after a rising edge
        for (int i = 0; i < 4; i++) tick();
        chk("drain_pre_rise", bus.clk_out, 1);
        tick();
        bus.en = 1'b0;
        tick();
        chk("drain_busy0", bus.busy, 1);
        chk("drain_high0", bus.clk_out, 1);
        tick();
        chk("drain_busy1", bus.busy, 1);
        chk("drain_high1", bus.clk_out, 1);
        tick();
        chk("drain_idle", bus.busy, 0);
        chk("drain_low", bus.clk_out, 0);
        chk("drain_acc", dut.acc, 0);
        chk("drain_edges", bus.edge_count, 104);

        // clamp of all-ones word
        bus.cfg_valid = 1'b1;
        bus.cfg_word  = 32'hFFFF_FFFF;
        tick();
        bus.cfg_valid = 1'b0;
        chk("clamp_inc", dut.inc, 32'h8000_0000);
        bus.en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            logic exp_bit;
            tick();
            exp_bit = ((i % 2) == 0);
            chk("clamp_toggle", bus.clk_out, exp_bit);
        end
        chk("clamp_edges", bus.edge_count, 108);

        // async reset with a pending word
        bus.cfg_valid = 1'b1;
        bus.cfg_word  = 32'h4000_0000;
        tick();
        bus.cfg_valid = 1'b0;
        chk("pend_ready_low", bus.cfg_ready, 0);
        chk("pend_clk_high", bus.clk_out, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_clk_out", bus.clk_out, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ready", bus.cfg_ready, 1);
        chk("arst_edges", bus.edge_count, 0);
        chk("arst_inc", dut.inc, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_inc", dut.inc, 0);
        chk("post_rst_ready", bus.cfg_ready, 1);
        chk("zero_word_busy", bus.busy, 1);
        chk("zero_word_frozen", bus.clk_out, 0);

`ifdef NCO_CLOCK_GEN_BURST_EN
        // burst of 5 edges, en held high afterwards
        bus.en = 1'b0;
        rst    = 1'b1;
        tick();
        rst           = 1'b0;
        bus.burst_len = 16'd5;
        bus.cfg_valid = 1'b1;
        bus.cfg_word  = 32'h4000_0000;
        tick();
        bus.cfg_valid = 1'b0;
        bus.en        = 1'b1;
        pulses        = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.burst_done) pulses++;
        end
        chk("burst_edges", bus.edge_count, 5);
        chk("burst_pulses", pulses, 1);
        chk("burst_idle", bus.busy, 0);
        chk("burst_low", bus.clk_out, 0);
`else
        pulses = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
